// File: rtl/pc_flags_unit.sv
// Program counter and processor status register, fed by the ALU flags.
// Computes the next PC and the condition result, and raises a one-cycle fetch flush after a taken branch.
module pc_flags_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       alu_psr,
    input  logic [4:0]       flag_mask,
    input  logic             pc_en,
    input  logic             br_valid,
    input  logic             br_abs,
    input  logic [3:0]       cond,
    input  logic [7:0]       disp,
    input  logic [WIDTH-1:0] rtarget,
    input  logic             link,
    output logic [WIDTH-1:0] pc,
    output logic [4:0]       psr,
    output logic             cond_true,
    output logic             taken,
    output logic             flush,
    output logic [WIDTH-1:0] link_addr
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Flag positions inside the PSR: {N,Z,L,F,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_F = 1;
    localparam int FLAG_L = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    logic [WIDTH-1:0] pc_r;
    logic [4:0]       psr_r;
    logic             flush_r;
    logic [WIDTH-1:0] link_addr_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] disp_ext_s;
    logic             cond_true_s;
    logic             taken_s;

    function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
        logic r;
        case (c)
            4'b0000: r = f[FLAG_Z];
            4'b0001: r = ~f[FLAG_Z];
            4'b0010: r = f[FLAG_C];
            4'b0011: r = ~f[FLAG_C];
            4'b0100: r = f[FLAG_L];
            4'b0101: r = ~f[FLAG_L];
            4'b0110: r = f[FLAG_N];
            4'b0111: r = ~f[FLAG_N];
            4'b1000: r = f[FLAG_F];
            4'b1001: r = ~f[FLAG_F];
            4'b1010: r = ~f[FLAG_L] & ~f[FLAG_Z];
            4'b1011: r = f[FLAG_L] | f[FLAG_Z];
            4'b1100: r = ~f[FLAG_N] & ~f[FLAG_Z];
            4'b1101: r = f[FLAG_N] | f[FLAG_Z];
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Condition decode is on the stored flags, so a same-cycle flag write is seen one cycle later.
    assign cond_true_s = cond_eval(cond, psr_r);
    assign taken_s     = br_valid & pc_en & cond_true_s;
    assign disp_ext_s  = {{(WIDTH-8){disp[7]}}, disp};

    // Next-PC selection: stall, relative branch, absolute jump or sequential.
    always_comb begin
        pc_next_s = pc_r;
        if (!pc_en) begin
            pc_next_s = pc_r;
        end else if (taken_s && !br_abs) begin
            pc_next_s = pc_r + disp_ext_s;
        end else if (taken_s && br_abs) begin
            pc_next_s = rtarget;
        end else begin
            pc_next_s = pc_r + PC_ONE;
        end
    end

    // State registers: PC, masked PSR write, flush and return address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            psr_r       <= 5'b00000;
            flush_r     <= 1'b0;
            link_addr_r <= {WIDTH{1'b0}};
        end else begin
            pc_r    <= pc_next_s;
            psr_r   <= (psr_r & ~flag_mask) | (alu_psr & flag_mask);
            flush_r <= taken_s;
            if (taken_s && br_abs && link) begin
                link_addr_r <= pc_r + PC_ONE;
            end else begin
                link_addr_r <= link_addr_r;
            end
        end
    end

    assign pc        = pc_r;
    assign psr       = psr_r;
    assign flush     = flush_r;
    assign link_addr = link_addr_r;
    assign cond_true = cond_true_s;
    assign taken     = taken_s;

endmodule

// File: tb/tb_pc_flags_unit.sv
// Scoreboard bench for pc_flags_unit: the driver queues hand-computed expectations,
// and a negedge monitor compares them against the DUT after the corresponding edge.
module tb_pc_flags_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  alu_psr;
    logic [4:0]  flag_mask;
    logic        pc_en;
    logic        br_valid;
    logic        br_abs;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] rtarget;
    logic        link;
    logic [15:0] pc;
    logic [4:0]  psr;
    logic        cond_true;
    logic        taken;
    logic        flush;
    logic [15:0] link_addr;

    pc_flags_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .alu_psr(alu_psr), .flag_mask(flag_mask),
        .pc_en(pc_en), .br_valid(br_valid), .br_abs(br_abs), .cond(cond),
        .disp(disp), .rtarget(rtarget), .link(link), .pc(pc), .psr(psr),
        .cond_true(cond_true), .taken(taken), .flush(flush), .link_addr(link_addr)
    );

    typedef struct {
        string       nm;
        int          cyc;
        logic [15:0] pc;
        logic [4:0]  psr;
        logic        fl;
        logic [15:0] lk;
        logic        ct;
        logic        tk;
    } exp_t;

    exp_t q[$];
    int   cyc_cnt = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   drv_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input string what, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, got, want);
        end
    endtask

    // Monitor: combinational outputs sampled one negedge earlier belong to the popped item's inputs.
    initial begin
        logic ct_prev;
        logic tk_prev;
        exp_t e;
        ct_prev = 1'b0;
        tk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
                e = q.pop_front();
                chk(e.nm, "pc",        pc,                  e.pc);
                chk(e.nm, "psr",       {11'd0, psr},        {11'd0, e.psr});
                chk(e.nm, "flush",     {15'd0, flush},      {15'd0, e.fl});
                chk(e.nm, "link_addr", link_addr,           e.lk);
                chk(e.nm, "cond_true", {15'd0, ct_prev},    {15'd0, e.ct});
                chk(e.nm, "taken",     {15'd0, tk_prev},    {15'd0, e.tk});
            end
            ct_prev = cond_true;
            tk_prev = taken;
        end
    end

    task automatic step(input string nm, input logic rst, input logic en, input logic bv,
                        input logic ba, input logic lk, input logic [3:0] c, input logic [7:0] d,
                        input logic [15:0] rt, input logic [4:0] ap, input logic [4:0] fm,
                        input logic [15:0] e_pc, input logic [4:0] e_psr, input logic e_fl,
                        input logic [15:0] e_lk, input logic e_ct, input logic e_tk);
        exp_t e;
        reset = rst; pc_en = en; br_valid = bv; br_abs = ba; link = lk;
        cond = c; disp = d; rtarget = rt; alu_psr = ap; flag_mask = fm;
        e.nm = nm; e.cyc = cyc_cnt + 1; e.pc = e_pc; e.psr = e_psr; e.fl = e_fl;
        e.lk = e_lk; e.ct = e_ct; e.tk = e_tk;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b1; br_valid = 1'b0; br_abs = 1'b0; link = 1'b0;
        cond = 4'd0; disp = 8'd0; rtarget = 16'd0; alu_psr = 5'd0; flag_mask = 5'd0;
        @(posedge clk);
        #1;
        //    name         rst  en   bv   ba   lk   cond     disp    rtarget   alu_psr   mask      pc        psr       fl   link      ct   tk
        step("rst1",      1'b1,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h0000,5'b00000,1'b0,16'h0000,1'b0,1'b0);
        step("rst2",      1'b1,1'b1,1'b0,1'b0,1'b0,4'b0001,8'h00,16'h0000,5'b00000,5'b00000,16'h0000,5'b00000,1'b0,16'h0000,1'b1,1'b0);
        step("run1",      1'b0,1'b1,1'b0,1'b0,1'b0,4'b1111,8'h00,16'h0000,5'b00000,5'b00000,16'h0001,5'b00000,1'b0,16'h0000,1'b0,1'b0);
        step("run2",      1'b0,1'b1,1'b0,1'b0,1'b0,4'b1010,8'h00,16'h0000,5'b00000,5'b00000,16'h0002,5'b00000,1'b0,16'h0000,1'b1,1'b0);
        step("run3",      1'b0,1'b1,1'b0,1'b0,1'b0,4'b1100,8'h00,16'h0000,5'b00000,5'b00000,16'h0003,5'b00000,1'b0,16'h0000,1'b1,1'b0);
        step("mask1",     1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b11111,5'b01000,16'h0004,5'b01000,1'b0,16'h0000,1'b0,1'b0);
        step("mask_hold", 1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h0005,5'b01000,1'b0,16'h0000,1'b1,1'b0);
        step("mask_clr",  1'b0,1'b1,1'b0,1'b0,1'b0,4'b1011,8'h00,16'h0000,5'b00000,5'b11111,16'h0006,5'b00000,1'b0,16'h0000,1'b1,1'b0);
        step("jmp10",     1'b0,1'b1,1'b1,1'b1,1'b0,4'b1110,8'h00,16'h0010,5'b01000,5'b01000,16'h0010,5'b01000,1'b1,16'h0000,1'b1,1'b1);
        step("beq_tk",    1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,8'hFC,16'h0000,5'b00000,5'b00000,16'h000C,5'b01000,1'b1,16'h0000,1'b1,1'b1);
        step("fl_drop",   1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h000D,5'b01000,1'b0,16'h0000,1'b1,1'b0);
        step("jmp10b",    1'b0,1'b1,1'b1,1'b1,1'b0,4'b1110,8'h00,16'h0010,5'b00000,5'b01000,16'h0010,5'b00000,1'b1,16'h0000,1'b1,1'b1);
        step("beq_nt",    1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,8'hFC,16'h0000,5'b00000,5'b00000,16'h0011,5'b00000,1'b0,16'h0000,1'b0,1'b0);
        step("blo_tk",    1'b0,1'b1,1'b1,1'b0,1'b0,4'b1010,8'h05,16'h0000,5'b00000,5'b00000,16'h0016,5'b00000,1'b1,16'h0000,1'b1,1'b1);
        step("jmp20",     1'b0,1'b1,1'b1,1'b1,1'b0,4'b1110,8'h00,16'h0020,5'b00000,5'b00000,16'h0020,5'b00000,1'b1,16'h0000,1'b1,1'b1);
        step("jal",       1'b0,1'b1,1'b1,1'b1,1'b1,4'b1110,8'h00,16'h1234,5'b00000,5'b00000,16'h1234,5'b00000,1'b1,16'h0021,1'b1,1'b1);
        step("jal_never", 1'b0,1'b1,1'b1,1'b1,1'b1,4'b1111,8'h00,16'h5555,5'b00000,5'b00000,16'h1235,5'b00000,1'b0,16'h0021,1'b0,1'b0);
        step("link_rel",  1'b0,1'b1,1'b1,1'b0,1'b1,4'b1110,8'h02,16'h0000,5'b00000,5'b00000,16'h1237,5'b00000,1'b1,16'h0021,1'b1,1'b1);
        step("jmpffff",   1'b0,1'b1,1'b1,1'b1,1'b0,4'b1110,8'h00,16'hFFFF,5'b00000,5'b00000,16'hFFFF,5'b00000,1'b1,16'h0021,1'b1,1'b1);
        step("wrap",      1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h0000,5'b00000,1'b0,16'h0021,1'b0,1'b0);
        step("wrap1",     1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h0001,5'b00000,1'b0,16'h0021,1'b0,1'b0);
        step("pc2",       1'b0,1'b1,1'b0,1'b0,1'b0,4'b0000,8'h00,16'h0000,5'b00000,5'b00000,16'h0002,5'b00000,1'b0,16'h0021,1'b0,1'b0);
        step("disp80",    1'b0,1'b1,1'b1,1'b0,1'b0,4'b1110,8'h80,16'h0000,5'b00000,5'b00000,16'hFF82,5'b00000,1'b1,16'h0021,1'b1,1'b1);
        step("stall",     1'b0,1'b0,1'b1,1'b1,1'b1,4'b1110,8'h00,16'h4444,5'b10000,5'b10000,16'hFF82,5'b10000,1'b0,16'h0021,1'b1,1'b0);
        step("beq_same",  1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,8'h10,16'h0000,5'b01000,5'b01000,16'hFF83,5'b11000,1'b0,16'h0021,1'b0,1'b0);
        step("beq_next",  1'b0,1'b1,1'b1,1'b0,1'b0,4'b0000,8'h10,16'h0000,5'b00000,5'b00000,16'hFF93,5'b11000,1'b1,16'h0021,1'b1,1'b1);
        step("rst_br",    1'b1,1'b1,1'b1,1'b1,1'b1,4'b1110,8'h00,16'h7777,5'b11111,5'b11111,16'h0000,5'b00000,1'b0,16'h0000,1'b1,1'b1);
        step("post_rst",  1'b0,1'b1,1'b0,1'b0,1'b0,4'b0111,8'h00,16'h0000,5'b00000,5'b00000,16'h0001,5'b00000,1'b0,16'h0000,1'b1,1'b0);
        drv_done = 1'b1;
    end

    // Bounded drain of the scoreboard, then the summary.
    initial begin
        wait (drv_done);
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_flags_unit.md
# pc_flags_unit

Holds the processor status register (PSR) and the program counter, and sits directly downstream of the 16-bit ALU. It captures the ALU's C/F/L/Z/N flags under a per-bit write mask and evaluates the 4-bit condition field of Bcond/Jcond/Scond instructions against the stored flags. It then computes the next PC: sequential, relative branch, or absolute jump. It also raises a one-cycle flush so fetch discards the instruction already in flight behind a taken branch.

## Interface

- WIDTH, 16, datapath and PC width
- RESET_PC, 0, PC value loaded on reset

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- alu_psr  in  5  ALU flags, bit order {N,Z,L,F,C} = [4:0] (C=bit0, F=bit1, L=bit2, Z=bit3, N=bit4)
- flag_mask  in  5  per-bit PSR write enable, same bit order
- pc_en  in  1  advance PC this cycle (low = stall)
- br_valid  in  1  branch/jump instruction in execute
- br_abs  in  1  0 = relative (Bcond), 1 = absolute (Jcond/JAL)
- cond  in  4  condition code
- disp  in  8  signed relative displacement
- rtarget  in  WIDTH  absolute jump target (from register file)
- link  in  1  save return address on a taken absolute jump
- pc  out  WIDTH  current PC
- psr  out  5  stored flags
- cond_true  out  1  combinational condition result (also used by Scond)
- taken  out  1  combinational: br_valid & pc_en & cond_true
- flush  out  1  registered, high one cycle after a taken branch
- link_addr  out  WIDTH  registered return address

## Operation

- PSR: at each edge, psr[i] <= alu_psr[i] when flag_mask[i]=1, else hold. PSR updates are independent of pc_en.
- cond_true decode from the *registered* psr. Flags written in the same cycle are not visible until the next cycle.
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111: 0
- Next PC, priority order:
  - reset: RESET_PC.
  - pc_en=0: hold. The branch is ignored, taken=0, and flush goes to 0.
  - taken & !br_abs: pc + sign_extend(disp).
  - taken & br_abs: rtarget.
  - otherwise: pc + 1.
- PC arithmetic is modulo 2^WIDTH and wraps silently.
- link_addr <= pc + 1 (pre-update pc, modulo 2^WIDTH) when taken & br_abs & link. Otherwise it holds. link with br_abs=0 has no effect.
- flush <= taken. It is 0 on any cycle following a non-taken or stalled cycle.
- Back-to-back taken branches: flush stays high for both cycles following them.

## Timing

- Reset values: pc=RESET_PC, psr=5'b00000, flush=0, link_addr=0.
  - With psr=0 after reset: cond_true=0 for EQ/CS/HI/GT/FS/HS/GE/1111, and 1 for NE/CC/LS/LE/FC/LO/LT/UC.
  - taken=0 while br_valid=0.
- Reset asserted mid-branch overrides everything at that edge. No flush is produced for the aborted branch.
- Latency:
  - cond_true and taken: 0 cycles (combinational from registers and inputs).
  - pc, psr, flush, link_addr: 1 edge.
- Flag-to-branch: a CMP in cycle n can feed a Bcond in cycle n+1 with no stall.

## Test plan

- Reset: hold reset for 2 cycles with pc_en=1 -> pc=0x0000, psr=0, flush=0. Release -> pc reads 0x0001, 0x0002, 0x0003 on successive edges.
- Flag mask:
  - alu_psr=5'b11111, flag_mask=5'b01000 -> psr=5'b01000.
  - Then alu_psr=0, mask=0 -> psr holds 5'b01000.
  - Then mask=5'b11111 -> psr=0.
- Taken relative branch: psr Z=1, pc=0x0010, cond=0000, disp=0xFC, br_valid=1 -> pc=0x000C and flush=1 next cycle. Flush returns to 0 the cycle after.
  - Repeat with Z=0 -> pc=0x0011, flush=0.
  - LO with L=0, Z=0 -> taken.
- JAL: pc=0x0020, cond=1110, br_abs=1, rtarget=0x1234, link=1 -> pc=0x1234, link_addr=0x0021.
  - cond=1111, same inputs -> pc=0x0021, link_addr unchanged.
- Boundaries:
  - pc=0xFFFF, pc_en=1 -> 0x0000.
  - pc=0x0002, disp=0x80, taken -> 0xFF82.
  - pc_en=0 with a taken-condition branch -> pc and link_addr hold, flush=0.
- Simultaneous events:
  - psr Z=0, flag_mask sets Z=1, same cycle BEQ -> not taken (pc+1). A BEQ the next cycle is taken.
  - Reset asserted together with a taken branch -> pc=RESET_PC, flush=0.
